// File: rtl/parity_chk_pkg.sv
// Shared types and helpers for the even/odd counter sequence checker.
package parity_chk_pkg;

  // Checker FSM states.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] TRACK   = 2'd2;
  localparam logic [1:0] RESYNC  = 2'd3;

  // Classification of one enabled sample against the previous one.
  typedef enum logic [1:0] {
    GOOD = 2'd0,
    MODE = 2'd1,
    BAD  = 2'd2
  } step_e;

  // Successor of prev for a given step kind, reduced mod 2^w.
  function automatic logic [31:0] next_exp(input logic [31:0] prev, input step_e kind,
                                           input int unsigned w);
    logic [31:0] sum;
    logic [31:0] mask;
    case (kind)
      GOOD:    sum = prev + 32'd2;
      MODE:    sum = prev + 32'd1;
      default: sum = prev;
    endcase
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return sum & mask;
  endfunction

endpackage

// File: rtl/parity_seq_checker_if.sv
// Sample/report bundle between the counter-side driver and the sequence checker.
interface parity_seq_checker_if #(
  parameter int unsigned W   = 3,
  parameter int unsigned ECW = 8
);
  logic           en;
  logic           oe;
  logic [W-1:0]   cnt_in;
  logic           clr;
  logic           locked;
  logic           err;
  logic [ECW-1:0] err_cnt;
  logic [W-1:0]   exp_out;
  logic [W-1:0]   err_seen;
  logic [W-1:0]   err_exp;

  modport master (
    output en, oe, cnt_in, clr,
    input  locked, err, err_cnt, exp_out, err_seen, err_exp
  );

  modport slave (
    input  en, oe, cnt_in, clr,
    output locked, err, err_cnt, exp_out, err_seen, err_exp
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority over increment).
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [Width-1:0] cnt
);

  logic [Width-1:0] cnt_q;

  // Count up to all-ones and hold there until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/parity_seq_checker.sv
// Monitor for the W-bit even/odd counter: checks each enabled sample is a +2 step with
// parity matching oe (or a +1 step on a mode change), tracks lock, pulses err and counts
// errors. Optional macro PARITY_CHK_CAPTURE_EN latches the first reported bad sample and
// its expected value into err_seen/err_exp until clr.
module parity_seq_checker
  import parity_chk_pkg::*;
#(
  parameter int unsigned W        = 3,
  parameter int unsigned ECW      = 8,
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  parity_seq_checker_if.slave  bus
);

  logic [1:0]   state_q, state_d;
  logic [3:0]   run_q, run_d;
  logic [W-1:0] prev_q;
  logic [W-1:0] exp_q;
  logic         oe_prev_q;
  logic         err_q, err_d;
  step_e        step;

  // Classify the incoming sample against the previous enabled sample.
  always_comb begin
    step = BAD;
    if ((bus.cnt_in == W'(next_exp(32'(prev_q), GOOD, W))) && (bus.cnt_in[0] == bus.oe)) begin
      step = GOOD;
    end else if ((bus.oe != oe_prev_q) && (bus.cnt_in[0] == bus.oe) &&
                 (bus.cnt_in == W'(next_exp(32'(prev_q), MODE, W)))) begin
      step = MODE;
    end
  end

  // Lock FSM: errors are reported only once lock has been achieved at least once.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    err_d   = 1'b0;
    if (bus.en) begin
      case (state_q)
        IDLE: begin
          state_d = ACQUIRE;
          run_d   = '0;
        end
        ACQUIRE, RESYNC: begin
          if (step != BAD) begin
            if ((run_q + 4'd1) == 4'(LOCK_CNT)) begin
              state_d = TRACK;
              run_d   = '0;
            end else begin
              run_d = run_q + 4'd1;
            end
          end else begin
            run_d = '0;
            err_d = (state_q == RESYNC);
          end
        end
        TRACK: begin
          if (step == BAD) begin
            state_d = RESYNC;
            run_d   = '0;
            err_d   = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          run_d   = '0;
        end
      endcase
    end
  end

  // State, previous-sample tracking and the one-cycle error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      run_q     <= '0;
      prev_q    <= '0;
      exp_q     <= '0;
      oe_prev_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      err_q   <= err_d;
      // Realign to every enabled sample, good or bad.
      if (bus.en) begin
        prev_q    <= bus.cnt_in;
        oe_prev_q <= bus.oe;
        exp_q     <= W'(next_exp(32'(bus.cnt_in), GOOD, W));
      end
    end
  end

  sat_counter #(
    .Width (ECW)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_d),
    .clr   (bus.clr),
    .cnt   (bus.err_cnt)
  );

  assign bus.locked  = (state_q == TRACK);
  assign bus.err     = err_q;
  assign bus.exp_out = exp_q;

`ifdef PARITY_CHK_CAPTURE_EN
  logic         captured_q;
  logic [W-1:0] seen_q;
  logic [W-1:0] cap_exp_q;

  // Hold the first reported error until cleared; later errors never overwrite it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      captured_q <= 1'b0;
      seen_q     <= '0;
      cap_exp_q  <= '0;
    end else if (bus.clr) begin
      captured_q <= 1'b0;
      seen_q     <= '0;
      cap_exp_q  <= '0;
    end else if (err_d && !captured_q) begin
      captured_q <= 1'b1;
      seen_q     <= bus.cnt_in;
      cap_exp_q  <= exp_q;
    end
  end

  assign bus.err_seen = seen_q;
  assign bus.err_exp  = cap_exp_q;
`else
  assign bus.err_seen = '0;
  assign bus.err_exp  = '0;
`endif

endmodule
